// File: rtl/ahb_addr_decoder.sv
// AHB address decoder for a 4-slave bus with a built-in default slave.
// Drives HSEL1..4 in the address phase and SEL, HREADY and HRESP in the data phase.
module ahb_addr_decoder #(
  parameter logic [31:0] ADDR_MASK = 32'hF000_0000,
  parameter logic [31:0] S1_BASE   = 32'h0000_0000,
  parameter logic [31:0] S2_BASE   = 32'h1000_0000,
  parameter logic [31:0] S3_BASE   = 32'h2000_0000,
  parameter logic [31:0] S4_BASE   = 32'h3000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HREADYOUT,
  input  logic        HRESP_IN,
  output logic        HSEL1,
  output logic        HSEL2,
  output logic        HSEL3,
  output logic        HSEL4,
  output logic [1:0]  SEL,
  output logic        DEF_ACTIVE,
  output logic        HREADY,
  output logic        HRESP
);

  typedef enum logic [1:0] {DIDLE, ERR1, ERR2} def_state_t;

  logic [31:0] masked;
  logic [3:0]  hit;
  logic [3:0]  hsel;
  logic [1:0]  hit_idx;
  logic        miss;
  logic        errq_nxt;

  logic [1:0]  sel_dp;
  logic        def_dp;
  logic        errq;
  logic        def_ready;
  def_state_t  state;

  assign masked = HADDR & ADDR_MASK;
  assign hit[0] = (masked == S1_BASE);
  assign hit[1] = (masked == S2_BASE);
  assign hit[2] = (masked == S3_BASE);
  assign hit[3] = (masked == S4_BASE);
  assign miss   = ~|hit;

  // Overlapping regions resolve to the lowest-numbered slave.
  always_comb begin
    hit_idx = 2'd0;
    if      (hit[0]) hit_idx = 2'd0;
    else if (hit[1]) hit_idx = 2'd1;
    else if (hit[2]) hit_idx = 2'd2;
    else if (hit[3]) hit_idx = 2'd3;
  end

  assign hsel     = (HRESET || miss) ? 4'b0000 : (4'b0001 << hit_idx);
  assign HSEL1    = hsel[0];
  assign HSEL2    = hsel[1];
  assign HSEL3    = hsel[2];
  assign HSEL4    = hsel[3];
  assign errq_nxt = miss & HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_dp    <= 2'd0;
      def_dp    <= 1'b1;
      errq      <= 1'b0;
      def_ready <= 1'b1;
      state     <= DIDLE;
    end else begin
      if (HREADY) begin
        sel_dp <= hit_idx;
        def_dp <= miss;
        errq   <= errq_nxt;
      end
      case (state)
        DIDLE: if (HREADY && errq_nxt) begin
          state     <= ERR1;
          def_ready <= 1'b0;
        end
        ERR1: begin
          state     <= ERR2;
          def_ready <= 1'b1;
        end
        ERR2: begin
          // HREADY is high in ERR2, so this edge always takes the next address phase.
          if (errq_nxt) begin
            state     <= ERR1;
            def_ready <= 1'b0;
          end else begin
            state     <= DIDLE;
          end
        end
        default: begin
          state     <= DIDLE;
          def_ready <= 1'b1;
        end
      endcase
    end
  end

  // errq is high exactly while the default slave is in ERR1/ERR2, so it doubles as its HRESP.
  assign SEL        = sel_dp;
  assign DEF_ACTIVE = def_dp;
  assign HREADY     = def_dp ? def_ready : HREADYOUT;
  assign HRESP      = def_dp ? errq      : HRESP_IN;

  logic unused_ok;
  assign unused_ok = HTRANS[0];

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// Directed bench for ahb_addr_decoder: decode sweep, default-slave error timing,
// wait states, back-to-back errors and reset abort.
module tb_ahb_addr_decoder;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADYOUT;
  logic        HRESP_IN;
  logic        HSEL1, HSEL2, HSEL3, HSEL4;
  logic [1:0]  SEL;
  logic        DEF_ACTIVE;
  logic        HREADY;
  logic        HRESP;

  int n_chk  = 0;
  int n_fail = 0;

  wire [3:0] hsel = {HSEL4, HSEL3, HSEL2, HSEL1};

  ahb_addr_decoder dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADYOUT(HREADYOUT), .HRESP_IN(HRESP_IN),
    .HSEL1(HSEL1), .HSEL2(HSEL2), .HSEL3(HSEL3), .HSEL4(HSEL4),
    .SEL(SEL), .DEF_ACTIVE(DEF_ACTIVE), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Advance to just after the next rising edge; inputs change here, outputs settle by #1 later.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HADDR = 32'h0000_0000; HTRANS = 2'd2;
    HREADYOUT = 1'b1; HRESP_IN = 1'b0;
    step(); step(); #1;
    n_chk++; if (SEL !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", SEL); end
    n_chk++; if (DEF_ACTIVE !== 1'b1) begin n_fail++; $display("FAIL reset_def got=%b exp=1", DEF_ACTIVE); end
    n_chk++; if (HREADY !== 1'b1) begin n_fail++; $display("FAIL reset_hready got=%b exp=1", HREADY); end
    n_chk++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp got=%b exp=0", HRESP); end
    n_chk++; if (hsel !== 4'b0000) begin n_fail++; $display("FAIL reset_hsel got=%b exp=0000", hsel); end
    HRESET = 1'b0; HTRANS = 2'd0;
  endtask

  task automatic test_decode();
    logic [31:0] addrs [4] = '{32'h0000_0010, 32'h1000_0000, 32'h2FFF_FFFC, 32'h3000_0004};
    logic [3:0]  onehot [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      step();
      if (i > 0) begin
        n_chk++; if (SEL !== 2'(i - 1)) begin n_fail++; $display("FAIL decode_sel[%0d] got=%0d exp=%0d", i - 1, SEL, i - 1); end
        n_chk++; if (DEF_ACTIVE !== 1'b0) begin n_fail++; $display("FAIL decode_def[%0d] got=%b exp=0", i - 1, DEF_ACTIVE); end
      end
      HADDR = addrs[i]; HTRANS = 2'd2;
      #1;
      n_chk++; if (hsel !== onehot[i]) begin n_fail++; $display("FAIL decode_hsel[%0d] got=%b exp=%b", i, hsel, onehot[i]); end
    end
    step();
    n_chk++; if (SEL !== 2'd3) begin n_fail++; $display("FAIL decode_sel[3] got=%0d exp=3", SEL); end
    HTRANS = 2'd0; HADDR = 32'h0000_0000;
  endtask

  task automatic test_unmapped_nonseq();
    step();
    HADDR = 32'h4000_0000; HTRANS = 2'd2;
    #1;
    n_chk++; if (hsel !== 4'b0000) begin n_fail++; $display("FAIL miss_hsel got=%b exp=0000", hsel); end
    step();
    HADDR = 32'h0000_0000; HTRANS = 2'd0; HRESP_IN = 1'b0;
    #1;
    n_chk++; if ({DEF_ACTIVE, HREADY, HRESP} !== 3'b101) begin n_fail++; $display("FAIL err1 got def/rdy/resp=%b exp=101", {DEF_ACTIVE, HREADY, HRESP}); end
    step();
    n_chk++; if ({HREADY, HRESP} !== 2'b11) begin n_fail++; $display("FAIL err2 got rdy/resp=%b exp=11", {HREADY, HRESP}); end
    step();
    n_chk++; if ({DEF_ACTIVE, SEL, HREADY, HRESP} !== 5'b0_00_10) begin n_fail++; $display("FAIL after_err got def/sel/rdy/resp=%b exp=000_10", {DEF_ACTIVE, SEL, HREADY, HRESP}); end
  endtask

  task automatic test_unmapped_idle();
    HADDR = 32'h8000_0000; HTRANS = 2'd0;
    step();
    n_chk++; if ({DEF_ACTIVE, HREADY, HRESP} !== 3'b110) begin n_fail++; $display("FAIL idle_miss got def/rdy/resp=%b exp=110", {DEF_ACTIVE, HREADY, HRESP}); end
    HREADYOUT = 1'b0; HRESP_IN = 1'b1;
    #1;
    n_chk++; if ({HREADY, HRESP} !== 2'b10) begin n_fail++; $display("FAIL idle_ignore_mux got rdy/resp=%b exp=10", {HREADY, HRESP}); end
    HREADYOUT = 1'b1; HRESP_IN = 1'b0;
  endtask

  task automatic test_wait_states();
    HADDR = 32'h2000_0000; HTRANS = 2'd2;
    step();
    HADDR = 32'h0000_0100; HTRANS = 2'd2; HREADYOUT = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      n_chk++; if ({SEL, HREADY} !== 3'b10_0) begin n_fail++; $display("FAIL wait[%0d] got sel/rdy=%b exp=100", k, {SEL, HREADY}); end
      n_chk++; if (hsel !== 4'b0001) begin n_fail++; $display("FAIL wait_hsel[%0d] got=%b exp=0001", k, hsel); end
    end
    step();
    HREADYOUT = 1'b1;
    #1;
    n_chk++; if ({SEL, HREADY} !== 3'b10_1) begin n_fail++; $display("FAIL wait_release got sel/rdy=%b exp=101", {SEL, HREADY}); end
    step();
    n_chk++; if ({SEL, DEF_ACTIVE} !== 3'b00_0) begin n_fail++; $display("FAIL wait_next got sel/def=%b exp=000", {SEL, DEF_ACTIVE}); end
    HTRANS = 2'd0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp [4] = '{2'b01, 2'b11, 2'b01, 2'b11};
    HADDR = 32'h5000_0000; HTRANS = 2'd2;
    for (int k = 0; k < 4; k++) begin
      step();
      case (k)
        0: begin HADDR = 32'h5000_0004; HTRANS = 2'd3; end
        2: begin HADDR = 32'h5000_0008; HTRANS = 2'd2; end
        default: ;
      endcase
      n_chk++; if ({HREADY, HRESP} !== exp[k]) begin n_fail++; $display("FAIL b2b[%0d] got rdy/resp=%b exp=%b", k, {HREADY, HRESP}, exp[k]); end
    end
    step();
    n_chk++; if ({HREADY, HRESP} !== 2'b01) begin n_fail++; $display("FAIL b2b_err1 got rdy/resp=%b exp=01", {HREADY, HRESP}); end
    HRESET = 1'b1;
    step();
    n_chk++; if ({DEF_ACTIVE, SEL, HREADY, HRESP} !== 5'b1_00_10) begin n_fail++; $display("FAIL reset_abort got def/sel/rdy/resp=%b exp=100_10", {DEF_ACTIVE, SEL, HREADY, HRESP}); end
    HRESET = 1'b0; HADDR = 32'h1000_0000; HTRANS = 2'd2;
    step();
    n_chk++; if ({DEF_ACTIVE, SEL, HRESP} !== 4'b0_01_0) begin n_fail++; $display("FAIL post_reset got def/sel/resp=%b exp=0010", {DEF_ACTIVE, SEL, HRESP}); end
    HTRANS = 2'd0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_unmapped_nonseq();
    test_unmapped_idle();
    test_wait_states();
    test_back_to_back();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
